// File: rtl/mul_share_arb.sv
// Shares one combinational 5x5 magnitude multiplier between NREQ sign-magnitude requesters.
// Define MUL_SHARE_FIXED_PRIO_EN for lowest-index-wins arbitration; otherwise round-robin.
module mul_share_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*6-1:0] req_a,
  input  logic [NREQ*6-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [4:0]        mul_a,
  output logic [4:0]        mul_b,
  input  logic [9:0]        mul_p,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [11:0]       resp_p
);

  // Handshake: a request transfers on an edge where req_valid[i] && req_ready[i];
  // a result transfers on an edge where resp_valid && resp_ready.
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state_q, state_d;
  logic [5:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  logic [IDW-1:0]  gid_q, gid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [11:0]     resp_p_q, resp_p_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_id;
  logic [NREQ-1:0] scan_vec;
  logic [5:0]      sel_a, sel_b;
  logic            accept;

`ifndef MUL_SHARE_FIXED_PRIO_EN
  logic [IDW-1:0]  ptr_q, ptr_d;
`endif

  // scan_vec[k] is the request k places above the current search origin
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
`ifdef MUL_SHARE_FIXED_PRIO_EN
    scan_vec = req_valid;
`else
    scan_vec = NREQ'({req_valid, req_valid} >> ptr_q);
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && scan_vec[k]) begin
        grant_found = 1'b1;
`ifdef MUL_SHARE_FIXED_PRIO_EN
        grant_id = IDW'(k);
`else
        grant_id = IDW'((int'(ptr_q) + k) % NREQ);
`endif
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_found && !reset;

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        req_ready[i] = accept;
        sel_a        = req_a[6*i +: 6];
        sel_b        = req_b[6*i +: 6];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    gid_d     = gid_q;
    resp_id_d = resp_id_q;
    resp_p_d  = resp_p_q;
`ifndef MUL_SHARE_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          gid_d   = grant_id;
          state_d = CALC;
        end
      end
      CALC: begin
        // -0 is kept: the sign is the operand sign XOR even for a zero product
        resp_p_d  = {op_a_q[5] ^ op_b_q[5], 1'b0, mul_p};
        resp_id_d = gid_q;
        state_d   = RESP;
      end
      RESP: begin
        if (resp_ready) begin
`ifndef MUL_SHARE_FIXED_PRIO_EN
          if (resp_id_q == IDW'(NREQ - 1)) ptr_d = '0;
          else                             ptr_d = resp_id_q + IDW'(1);
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      gid_q     <= '0;
      resp_id_q <= '0;
      resp_p_q  <= '0;
`ifndef MUL_SHARE_FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      gid_q     <= gid_d;
      resp_id_q <= resp_id_d;
      resp_p_q  <= resp_p_d;
`ifndef MUL_SHARE_FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign mul_a      = op_a_q[4:0];
  assign mul_b      = op_b_q[4:0];
  assign resp_valid = (state_q == RESP);
  assign resp_id    = resp_id_q;
  assign resp_p     = resp_p_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: directed scenarios plus random traffic, checked by a
// scoreboard fed from a cycle-level behavioural model of arbitration and results.
module tb_mul_share_arb;
  localparam int NREQ = 2;
  localparam int IDW  = 2;
  localparam int RW   = 6 * NREQ;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [RW-1:0]   req_a = '0;
  logic [RW-1:0]   req_b = '0;
  logic [NREQ-1:0] req_ready;
  logic [4:0]      mul_a, mul_b;
  logic [9:0]      mul_p;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [IDW-1:0]  resp_id;
  logic [11:0]     resp_p;

  always #5 clk = ~clk;

  // stand-in for the external multiplier core
  assign mul_p = {5'b0, mul_a} * {5'b0, mul_b};

  mul_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_p(resp_p)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [IDW+11:0] exp_q[$];

  bit              m_busy = 1'b0;
  int              m_age = 0;
  int              m_ptr = 0;
  int              m_owner = 0;
  logic [4:0]      m_a = '0, m_b = '0;
  logic [NREQ-1:0] acc_pulse = '0;

  function automatic logic bit_of(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [5:0] op_of(input logic [RW-1:0] v, input int i);
    logic [RW-1:0] t;
    t = v >> (6 * i);
    return t[5:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor + reference model, sampled on the falling edge
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    logic            exp_rv;
    logic [IDW+11:0] e;
    logic [5:0]      oa, ob;
    logic [9:0]      prod;
    int              idx;
    if (reset) begin
      m_busy = 1'b0; m_age = 0; m_ptr = 0; m_a = '0; m_b = '0;
      acc_pulse = '0;
      exp_q.delete();
    end else begin
      if (m_busy) m_age++;
      exp_rv  = m_busy && (m_age >= 2);
      exp_rdy = '0;
      if (!m_busy) begin
        for (int k = 0; k < NREQ; k++) begin
`ifdef MUL_SHARE_FIXED_PRIO_EN
          idx = k;
`else
          idx = (m_ptr + k) % NREQ;
`endif
          if (exp_rdy == '0 && bit_of(req_valid, idx)) exp_rdy = NREQ'(1) << idx;
        end
      end
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("resp_valid", 32'(resp_valid), 32'(exp_rv));
      check("mul_a", 32'(mul_a), 32'(m_a));
      check("mul_b", 32'(mul_b), 32'(m_b));
      if (exp_rv) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL resp_queue: got result with empty expected queue, expected none");
        end else begin
          e = exp_q[0];
          check("resp_id", 32'(resp_id), 32'(e[IDW+11:12]));
          check("resp_p", 32'(resp_p), 32'(e[11:0]));
          if (resp_ready) begin
            void'(exp_q.pop_front());
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NREQ;
          end
        end
      end
      acc_pulse = exp_rdy;
      for (int i = 0; i < NREQ; i++) begin
        if (bit_of(exp_rdy, i)) begin
          oa   = op_of(req_a, i);
          ob   = op_of(req_b, i);
          prod = {5'b0, oa[4:0]} * {5'b0, ob[4:0]};
          exp_q.push_back({IDW'(i), oa[5] ^ ob[5], 1'b0, prod});
          m_busy = 1'b1; m_age = 0; m_owner = i;
          m_a = oa[4:0]; m_b = ob[4:0];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [5:0] a, input logic [5:0] b);
    logic [RW-1:0] m;
    m = RW'(6'h3f) << (6 * i);
    req_a = (req_a & ~m) | (RW'(a) << (6 * i));
    req_b = (req_b & ~m) | (RW'(b) << (6 * i));
    req_valid = req_valid | (NREQ'(1) << i);
  endtask

  task automatic wait_acc(input int i);
    int n;
    n = 0;
    do begin @(posedge clk); n++; end while (!bit_of(acc_pulse, i) && n < 40);
    #1;
    if (!bit_of(acc_pulse, i)) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: requester %0d not accepted, expected accept", i);
    end
    req_valid = req_valid & ~(NREQ'(1) << i);
  endtask

  task automatic wait_any_acc(output logic [NREQ-1:0] got);
    int n;
    n = 0;
    do begin @(posedge clk); n++; end while (acc_pulse == '0 && n < 40);
    #1;
    got = acc_pulse;
    if (got == '0) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: no requester accepted, expected accept");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_busy || req_valid != '0) && n < 80) begin
      tick();
      req_valid = req_valid & ~acc_pulse;
      n++;
    end
    if (m_busy || req_valid != '0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: busy=%0d valid=%0h, expected idle", m_busy, req_valid);
    end
    tick();
  endtask

  initial begin
    logic [NREQ-1:0] got;
    // reset with every requester asserting
    req_valid = '1;
    req_a = {RW{1'b1}};
    req_b = {RW{1'b1}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_p", 32'(resp_p), 32'h0);
    check("rst_resp_id", 32'(resp_id), 32'h0);
    check("rst_mul_a", 32'(mul_a), 32'h0);
    check("rst_mul_b", 32'(mul_b), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;
    tick();

    // fairness: both requesters held valid for four operations
    set_req(0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    set_req(1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    for (int n = 0; n < 4; n++) begin
      wait_any_acc(got);
      for (int i = 0; i < NREQ; i++) begin
        if (bit_of(got, i)) begin
          if (n < 3) set_req(i, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
          else       req_valid = req_valid & ~(NREQ'(1) << i);
        end
      end
    end
    drain();

    // single request, maximum magnitude, signed zero
    set_req(0, 6'b000011, 6'b100101); wait_acc(0); drain();
    set_req(1, 6'b011111, 6'b011111); wait_acc(1); drain();
    set_req(0, 6'b100000, 6'b000111); wait_acc(0); drain();

    // backpressure with a second request arriving while busy
    resp_ready = 1'b0;
    set_req(1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    wait_acc(1);
    set_req(0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    repeat (7) tick();
    resp_ready = 1'b1;
    drain();

    // reset while in CALC, with the pointer pre-set to 1
    set_req(0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))); wait_acc(0); drain();
    set_req(1, 6'b010101, 6'b101010);
    wait_acc(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    set_req(1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    drain();

    // random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      tick();
      req_valid = req_valid & ~acc_pulse;
      for (int i = 0; i < NREQ; i++) begin
        if (!bit_of(req_valid, i) && $urandom_range(0, 2) == 0)
          set_req(i, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    resp_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
